inv_keygen_seq: RTL and testbench
=================================

// Module: inv_keygen_seq
// PURPOSE
//  Sequential AES-128 inverse key schedule. Accepts the final (round-10) round key and walks the
//  expansion backwards, emitting round keys 10,9,...,0 one per handshake to the decryption datapath.
//  It is the decrypt-side counterpart of the forward one-round key expansion used by the cipher.
//  Removes the need to store all 11 round keys: only the last key is kept from encryption setup.
// PARAMETERS
//  NR        10   number of rounds; only 10 (AES-128) supported, elaboration error otherwise
//  KW        128  key width in bits; fixed to 128
// PORTS
//  clk        in   1    system clock, all state on rising edge
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    pulse/level: load key_in and begin a backward walk (sampled in IDLE only)
//  key_in     in   128  round-10 key, word w40 in [127:96] ... w43 in [31:0]
//  key_out    out  128  current round key, same word ordering as key_in
//  rnd        out  4    round number of key_out (10 down to 0)
//  key_valid  out  1    key_out/rnd valid
//  key_ready  in   1    consumer accepts key_out when key_valid & key_ready
//  busy       out  1    high from accepted start until the round-0 key is accepted
//  done       out  1    one-cycle pulse in the cycle after round-0 key is accepted
// BEHAVIOUR
//  Reset: state=IDLE, key reg=0, rnd=0, key_valid=0, busy=0, done=0.
//  FSM: IDLE -> EMIT on start; EMIT -> EMIT on accept with rnd>0 (step back); EMIT -> DONE on
//   accept with rnd==0; DONE -> IDLE unconditionally (done=1 for that single cycle).
//  Load: IDLE & start -> key reg<=key_in, rnd<=10, key_valid=1 next cycle (latency 1 cycle).
//  Step (on accept, rnd=r>0), with current words (a0,a1,a2,a3):
//   p3=a3^a2; p2=a2^a1; p1=a1^a0; p0=a0^SubWord(RotWord(p3))^Rcon(r), where Rcon(r) is the byte
//   {01,02,04,08,10,20,40,80,1b,36}[r-1] in bits [31:24]; RotWord = byte rotate left by one.
//   key reg<=(p0,p1,p2,p3), rnd<=r-1 in the same edge; key_valid stays 1 (back-to-back, 1 key/cycle).
//  Holding: while key_valid & !key_ready, key_out and rnd are stable.
//  start while busy: ignored. start in DONE cycle: ignored (accepted next cycle in IDLE).
//  Reset mid-walk: asynchronous return to reset values; partially emitted sequence abandoned.
//  Combinational path: 4 S-box lookups + XORs from key reg to next-key; no pipelining.
// CONFIGURATION
//  INV_MIXCOL_EN defined: key_out for rnd 1..9 = InvMixColumns(key reg) per 32-bit column
//   (equivalent inverse cipher keys); rnd 10 and 0 output raw. Internal walk always uses raw keys.
//  INV_MIXCOL_EN undefined: key_out = key reg for all rounds; no InvMixColumns logic built.
// STRUCTURE
//  Shared package aes_pkg: Rcon table function, state enum {IDLE,EMIT,DONE}, constant NR=10.
//  Reuse existing sbox (4 instances). One natural sub-module: inv_mixcol_word (32-bit column,
//   GF(2^8) xtime multiplies by 0e/0b/0d/09), instanced 4x only under INV_MIXCOL_EN.
// TESTING
//  1 FIPS-197 A.1: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 -> rnd10 then rnd9
//    ac7766f319fadc2128d12941575c006e ... rnd0 2b7e151628aed2a6abf7158809cf4f3c, done on cycle 12.
//  2 Backpressure: random key_ready stalls -> key_out/rnd stable while stalled, full 11-key
//    sequence identical to test 1, no key skipped or repeated.
//  3 start asserted during walk (rnd=5) with different key_in -> ignored, sequence unchanged.
//  4 rst_n low at rnd=4 -> key_valid/busy drop immediately, outputs 0; new start restarts at rnd10.
//  5 Round trip: random key K, forward expand in model to round 10, feed -> rnd0 output == K (1000x).
//  6 INV_MIXCOL_EN build, A.1 key -> rnd9 output == InvMixColumns(ac7766f3...) from model;
//    rnd10/rnd0 unchanged vs test 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, key-walk FSM states, Rcon table and GF(2^8) xtime.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Rcon byte used when producing round key r (r = 1..10); zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_keygen_seq_inv_mixcol_word.sv
// InvMixColumns on one 32-bit column (byte 0 in [31:24]) built from xtime chains.
module inv_mixcol_word
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_b   [4];
  logic [7:0] w_x2  [4];
  logic [7:0] w_x4  [4];
  logic [7:0] w_x8  [4];
  logic [7:0] w_m09 [4];
  logic [7:0] w_m0b [4];
  logic [7:0] w_m0d [4];
  logic [7:0] w_m0e [4];

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign w_b[g]   = i_col[31-8*g -: 8];
    assign w_x2[g]  = xtime(w_b[g]);
    assign w_x4[g]  = xtime(w_x2[g]);
    assign w_x8[g]  = xtime(w_x4[g]);
    assign w_m09[g] = w_x8[g] ^ w_b[g];
    assign w_m0b[g] = w_x8[g] ^ w_x2[g] ^ w_b[g];
    assign w_m0d[g] = w_x8[g] ^ w_x4[g] ^ w_b[g];
    assign w_m0e[g] = w_x8[g] ^ w_x4[g] ^ w_x2[g];
  end

  assign o_col[31:24] = w_m0e[0] ^ w_m0b[1] ^ w_m0d[2] ^ w_m09[3];
  assign o_col[23:16] = w_m09[0] ^ w_m0e[1] ^ w_m0b[2] ^ w_m0d[3];
  assign o_col[15:8]  = w_m0d[0] ^ w_m09[1] ^ w_m0e[2] ^ w_m0b[3];
  assign o_col[7:0]   = w_m0b[0] ^ w_m0d[1] ^ w_m09[2] ^ w_m0e[3];

endmodule

// File: rtl/sbox.sv
// AES forward S-box as a constant lookup table.
module sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  // NOTE: this is a constant ROM, not storage; it has no reset and needs none.
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign o_out = SBOX[i_in];

endmodule

// File: rtl/inv_keygen_seq.sv
// Sequential AES-128 inverse key schedule: emits round keys 10..0, one per handshake.
// Optional build macro INV_MIXCOL_EN: rounds 1..9 are output through InvMixColumns.
module inv_keygen_seq
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] key_out,
  output logic [3:0]   rnd,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  if (NR != aes_pkg::NR || KW != aes_pkg::KW) begin : g_bad_cfg
    $error("inv_keygen_seq supports only AES-128 (NR=10, KW=128)");
  end

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_key;
  logic [3:0]   r_rnd;
  logic         w_load;
  logic         w_accept;
  logic [31:0]  w_a0, w_a1, w_a2, w_a3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;

  assign w_load   = (r_state == ST_IDLE) && start;
  assign w_accept = (r_state == ST_EMIT) && key_ready;

  assign {w_a0, w_a1, w_a2, w_a3} = r_key;

  // Undo one forward expansion step: recover the previous round's four words.
  assign w_p3  = w_a3 ^ w_a2;
  assign w_p2  = w_a2 ^ w_a1;
  assign w_p1  = w_a1 ^ w_a0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .i_in  (w_rot[8*g +: 8]),
      .o_out (w_sub[8*g +: 8])
    );
  end

  assign w_p0 = w_a0 ^ w_sub ^ {rcon(r_rnd), 24'h0};

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_EMIT;
      ST_EMIT: if (w_accept && (r_rnd == 4'd0)) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignment so register update order never matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_rnd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_key <= key_in;
        r_rnd <= 4'(NR);
      end else if (w_accept && (r_rnd != 4'd0)) begin
        r_key <= {w_p0, w_p1, w_p2, w_p3};
        r_rnd <= r_rnd - 4'd1;
      end
    end
  end

`ifdef INV_MIXCOL_EN
  logic [127:0] w_imc;

  for (genvar g = 0; g < 4; g++) begin : g_imc
    inv_mixcol_word u_imc (
      .i_col (r_key[32*g +: 32]),
      .o_col (w_imc[32*g +: 32])
    );
  end

  // First and last round keys are used raw by the equivalent inverse cipher.
  assign key_out = ((r_rnd == 4'd0) || (r_rnd == 4'(NR))) ? r_key : w_imc;
`else
  assign key_out = r_key;
`endif

  assign rnd       = r_rnd;
  assign key_valid = (r_state == ST_EMIT);
  assign busy      = (r_state == ST_EMIT);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_inv_keygen_seq.sv
// Directed bench for inv_keygen_seq: FIPS-197 A.1 walk, backpressure, ignored start,
// mid-walk reset and forward/backward round trips against a forward-expansion model.
module tb_inv_keygen_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] key_out;
  logic [3:0]   rnd;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_rk [11];

  localparam logic [127:0] A1_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [7:0] RC [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [7:0] SB [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  inv_keygen_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .key_out   (key_out),
    .rnd       (rnd),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Forward FIPS-197 key expansion of k into exp_rk[0..10].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]};
        t = t ^ {RC[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   c [4];
    for (int col = 0; col < 4; col++) begin
      for (int j = 0; j < 4; j++) c[j] = s[127-32*col-8*j -: 8];
      o[127-32*col -: 8] = gmul(c[0],8'h0e) ^ gmul(c[1],8'h0b) ^ gmul(c[2],8'h0d) ^ gmul(c[3],8'h09);
      o[119-32*col -: 8] = gmul(c[0],8'h09) ^ gmul(c[1],8'h0e) ^ gmul(c[2],8'h0b) ^ gmul(c[3],8'h0d);
      o[111-32*col -: 8] = gmul(c[0],8'h0d) ^ gmul(c[1],8'h09) ^ gmul(c[2],8'h0e) ^ gmul(c[3],8'h0b);
      o[103-32*col -: 8] = gmul(c[0],8'h0b) ^ gmul(c[1],8'h0d) ^ gmul(c[2],8'h09) ^ gmul(c[3],8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] exp_out(input int r);
`ifdef INV_MIXCOL_EN
    if (r >= 1 && r <= 9) return inv_mix(exp_rk[r]);
`endif
    return exp_rk[r];
  endfunction

  // One full backward walk of key k against exp_rk; optional random stalls and a start poke at rnd 5.
  task automatic walk(input logic [127:0] k, input bit stall, input bit poke, input string tag);
    int r;
    int cyc;
    key_in = k;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r   = 10;
    cyc = 0;
    while (r >= 0 && cyc < 400) begin
      check({tag, "_valid"}, 128'(key_valid), 128'(1));
      check({tag, "_busy"},  128'(busy),      128'(1));
      check({tag, "_rnd"},   128'(rnd),       128'(r));
      check({tag, "_key"},   key_out,         exp_out(r));
      key_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && r == 5) begin
        start  = 1'b1;
        key_in = ~k;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (key_ready) r--;
      cyc++;
    end
    check({tag, "_cycles_ok"}, 128'(r < 0), 128'(1));
    if (!stall) check({tag, "_latency"}, 128'(cyc + 1), 128'(12));
    check({tag, "_done"},       128'(done),      128'(1));
    check({tag, "_done_valid"}, 128'(key_valid), 128'(0));
    check({tag, "_done_busy"},  128'(busy),      128'(0));
    key_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 128'(done),      128'(0));
    check({tag, "_idle_valid"}, 128'(key_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] k;
    rst_n     = 1'b0;
    start     = 1'b0;
    key_in    = '0;
    key_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(key_valid), 128'(0));
    check("rst_busy",  128'(busy),      128'(0));
    check("rst_done",  128'(done),      128'(0));
    check("rst_rnd",   128'(rnd),       128'(0));
    check("rst_key",   key_out,         128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 11; r++) exp_rk[r] = A1_RK[r];
    walk(A1_RK[10], 1'b0, 1'b0, "a1");
    walk(A1_RK[10], 1'b1, 1'b0, "stall");
    walk(A1_RK[10], 1'b0, 1'b1, "poke");

    // Reset in the middle of a walk, then a clean restart.
    key_in = A1_RK[10];
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_rnd4", 128'(rnd), 128'(4));
    check("mid_key4", key_out,   exp_out(4));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(key_valid), 128'(0));
    check("mid_rst_busy",  128'(busy),      128'(0));
    check("mid_rst_rnd",   128'(rnd),       128'(0));
    check("mid_rst_key",   key_out,         128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    walk(A1_RK[10], 1'b0, 1'b0, "restart");

    for (int n = 0; n < 1000; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      walk(exp_rk[10], n[0], 1'b0, "trip");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
